// File: rtl/proc_sequencer.sv
// Multi-cycle processor control sequencer: fetch/decode/exec/mem/writeback FSM with handshakes.
// Optional memory-handshake watchdog enabled by defining SEQ_MEM_TIMEOUT_EN.
module proc_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [11:0] instr_i,
  input  logic        zero_i,
  input  logic        imem_ack_i,
  input  logic        dmem_ack_i,
  output logic        imem_req_o,
  output logic        ir_load_o,
  output logic [2:0]  opcode_o,
  output logic        funct_o,
  output logic [1:0]  imm_code_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic        reg_we_o,
  output logic        pc_inc_o,
  output logic        pc_load_o,
  output logic [2:0]  state_o,
  output logic        halted_o,
  output logic        err_o,
  output logic [15:0] retired_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6,
    ERROR  = 3'd7
  } state_t;

  localparam logic [2:0] OP_MEM  = 3'd4;
  localparam logic [2:0] OP_HALT = 3'd5;
  localparam logic [2:0] OP_BR   = 3'd6;

  state_t      state_r;
  logic [2:0]  opcode_r;
  logic        funct_r;
  logic [1:0]  imm_code_r;
  logic [15:0] retired_r;
  logic        wait_hit_s;

  logic imem_req_s, ir_load_s, dmem_req_s, dmem_we_s, reg_we_s, pc_inc_s, pc_load_s;

  // Instruction bits [7:2] belong to other units; only opcode/funct/imm_code are latched here.
  logic unused_instr_s;
  assign unused_instr_s = ^instr_i[7:2];

`ifdef SEQ_MEM_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wait_cnt_r;
  logic       err_r;
  logic       waiting_s;

  assign waiting_s  = ((state_r == FETCH) && !imem_ack_i) || ((state_r == MEM) && !dmem_ack_i);
  assign wait_hit_s = waiting_s && (wait_cnt_r == TIMEOUT_LAST);

  // Wait counter: counts unacknowledged request cycles, zero whenever no request is pending.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wait_cnt_r <= 8'd0;
    end else if (waiting_s) begin
      wait_cnt_r <= wait_cnt_r + 8'd1;
    end else begin
      wait_cnt_r <= 8'd0;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      err_r <= 1'b0;
    end else if (wait_hit_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err_o = err_r;
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign wait_hit_s = 1'b0;
  assign err_o      = 1'b0;
`endif

  // Main sequencer: state, instruction-field latch and retired-instruction counter.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_r    <= IDLE;
      opcode_r   <= 3'd0;
      funct_r    <= 1'b0;
      imm_code_r <= 2'd0;
      retired_r  <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_i) state_r <= FETCH;
        end
        FETCH: begin
          if (imem_ack_i) begin
            opcode_r   <= instr_i[11:9];
            funct_r    <= instr_i[8];
            imm_code_r <= instr_i[1:0];
            state_r    <= DECODE;
          end else if (wait_hit_s) begin
            state_r <= ERROR;
          end
        end
        DECODE: begin
          state_r <= (opcode_r == OP_HALT) ? HALT : EXEC;
        end
        EXEC: begin
          if (opcode_r == OP_MEM) begin
            state_r <= MEM;
          end else if (opcode_r == OP_BR) begin
            state_r   <= FETCH;
            retired_r <= retired_r + 16'd1;
          end else begin
            state_r <= WB;
          end
        end
        MEM: begin
          if (dmem_ack_i) begin
            if (funct_r) begin
              state_r   <= FETCH;
              retired_r <= retired_r + 16'd1;
            end else begin
              state_r <= WB;
            end
          end else if (wait_hit_s) begin
            state_r <= ERROR;
          end
        end
        WB: begin
          state_r   <= FETCH;
          retired_r <= retired_r + 16'd1;
        end
        HALT:    state_r <= HALT;
        ERROR:   state_r <= ERROR;
        default: state_r <= IDLE;
      endcase
    end
  end

  // State-qualified strobes; acks and zero_i only matter in the state that expects them.
  always_comb begin
    imem_req_s = 1'b0;
    ir_load_s  = 1'b0;
    dmem_req_s = 1'b0;
    dmem_we_s  = 1'b0;
    reg_we_s   = 1'b0;
    pc_inc_s   = 1'b0;
    pc_load_s  = 1'b0;
    case (state_r)
      FETCH: begin
        imem_req_s = 1'b1;
        ir_load_s  = imem_ack_i;
      end
      EXEC: begin
        if (opcode_r == OP_BR) begin
          if (funct_r == zero_i) begin
            pc_load_s = 1'b1;
          end else begin
            pc_inc_s = 1'b1;
          end
        end else begin
          pc_inc_s = 1'b0;
        end
      end
      MEM: begin
        dmem_req_s = 1'b1;
        dmem_we_s  = funct_r;
        pc_inc_s   = dmem_ack_i & funct_r;
      end
      WB: begin
        reg_we_s = 1'b1;
        pc_inc_s = 1'b1;
      end
      default: begin
        imem_req_s = 1'b0;
      end
    endcase
  end

  assign imem_req_o = imem_req_s;
  assign ir_load_o  = ir_load_s;
  assign dmem_req_o = dmem_req_s;
  assign dmem_we_o  = dmem_we_s;
  assign reg_we_o   = reg_we_s;
  assign pc_inc_o   = pc_inc_s;
  assign pc_load_o  = pc_load_s;
  assign opcode_o   = opcode_r;
  assign funct_o    = funct_r;
  assign imm_code_o = imm_code_r;
  assign state_o    = state_r;
  assign halted_o   = (state_r == HALT);
  assign retired_o  = retired_r;

endmodule

// File: tb/tb_proc_sequencer.sv
// Randomized bench for proc_sequencer: expected per-cycle traces are generated per instruction
// from the sequencing rules and compared against the DUT each cycle.
module tb_proc_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_n_i, start_i, zero_i, imem_ack_i, dmem_ack_i;
  logic [11:0] instr_i;
  logic        imem_req_o, ir_load_o, funct_o, dmem_req_o, dmem_we_o;
  logic        reg_we_o, pc_inc_o, pc_load_o, halted_o, err_o;
  logic [2:0]  opcode_o, state_o;
  logic [1:0]  imm_code_o;
  logic [15:0] retired_o;

  proc_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .instr_i(instr_i),
    .zero_i(zero_i), .imem_ack_i(imem_ack_i), .dmem_ack_i(dmem_ack_i),
    .imem_req_o(imem_req_o), .ir_load_o(ir_load_o), .opcode_o(opcode_o),
    .funct_o(funct_o), .imm_code_o(imm_code_o), .dmem_req_o(dmem_req_o),
    .dmem_we_o(dmem_we_o), .reg_we_o(reg_we_o), .pc_inc_o(pc_inc_o),
    .pc_load_o(pc_load_o), .state_o(state_o), .halted_o(halted_o),
    .err_o(err_o), .retired_o(retired_o)
  );

  always #5 clk_i = ~clk_i;

  // strobe vector order: {imem_req, ir_load, dmem_req, dmem_we, reg_we, pc_inc, pc_load}
  localparam logic [6:0] S_IREQ = 7'b100_0000;
  localparam logic [6:0] S_IRLD = 7'b010_0000;
  localparam logic [6:0] S_DREQ = 7'b001_0000;
  localparam logic [6:0] S_DWE  = 7'b000_1000;
  localparam logic [6:0] S_RWE  = 7'b000_0100;
  localparam logic [6:0] S_INC  = 7'b000_0010;
  localparam logic [6:0] S_LD   = 7'b000_0001;

  typedef struct {
    logic [2:0]  st;
    logic [6:0]  strb;
    logic        start, iack, dack, zero;
    logic [11:0] instr;
    logic        load, retire;
  } cyc_t;

  cyc_t        trace[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] m_ret;
  logic [2:0]  m_op;
  logic        m_funct;
  logic [1:0]  m_imm;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [11:0] rnd12();
    return 12'($urandom_range(0, 4095));
  endfunction

  task automatic push(input logic [2:0] st, input logic [6:0] strb, input logic start,
                      input logic iack, input logic dack, input logic zero,
                      input logic [11:0] instr, input logic load, input logic retire);
    cyc_t c;
    c.st = st; c.strb = strb; c.start = start; c.iack = iack; c.dack = dack;
    c.zero = zero; c.instr = instr; c.load = load; c.retire = retire;
    trace.push_back(c);
  endtask

  task automatic start_seq(input int idle_cycles);
    repeat (idle_cycles) push(3'd0, 7'b0, 1'b0, rnd1(), rnd1(), rnd1(), rnd12(), 1'b0, 1'b0);
    push(3'd0, 7'b0, 1'b1, rnd1(), rnd1(), rnd1(), rnd12(), 1'b0, 1'b0);
  endtask

  // Expected trace of one instruction with fd fetch-wait and md mem-wait cycles.
  task automatic build_instr(input logic [11:0] ins, input int fd, input int md, input logic z);
    logic [2:0] op;
    logic       f;
    logic [6:0] ms;
    op = ins[11:9];
    f  = ins[8];
    ms = f ? (S_DREQ | S_DWE) : S_DREQ;
    for (int i = 0; i < fd; i++)
      push(3'd1, S_IREQ, rnd1(), 1'b0, rnd1(), rnd1(), rnd12(), 1'b0, 1'b0);
    push(3'd1, S_IREQ | S_IRLD, rnd1(), 1'b1, rnd1(), rnd1(), ins, 1'b1, 1'b0);
    push(3'd2, 7'b0, rnd1(), rnd1(), rnd1(), rnd1(), rnd12(), 1'b0, 1'b0);
    if (op == 3'd5) begin
      push(3'd6, 7'b0, rnd1(), rnd1(), rnd1(), rnd1(), rnd12(), 1'b0, 1'b0);
    end else if (op == 3'd6) begin
      push(3'd3, (f == z) ? S_LD : S_INC, rnd1(), rnd1(), rnd1(), z, rnd12(), 1'b0, 1'b1);
    end else if (op == 3'd4) begin
      push(3'd3, 7'b0, rnd1(), rnd1(), rnd1(), rnd1(), rnd12(), 1'b0, 1'b0);
      for (int i = 0; i < md; i++)
        push(3'd4, ms, rnd1(), rnd1(), 1'b0, rnd1(), rnd12(), 1'b0, 1'b0);
      push(3'd4, f ? (ms | S_INC) : ms, rnd1(), rnd1(), 1'b1, rnd1(), rnd12(), 1'b0, f);
      if (!f) push(3'd5, S_RWE | S_INC, rnd1(), rnd1(), rnd1(), rnd1(), rnd12(), 1'b0, 1'b1);
    end else begin
      push(3'd3, 7'b0, rnd1(), rnd1(), rnd1(), rnd1(), rnd12(), 1'b0, 1'b0);
      push(3'd5, S_RWE | S_INC, rnd1(), rnd1(), rnd1(), rnd1(), rnd12(), 1'b0, 1'b1);
    end
  endtask

  task automatic run_trace();
    while (trace.size() > 0) begin
      cyc_t e;
      e = trace.pop_front();
      @(negedge clk_i);
      start_i = e.start; imem_ack_i = e.iack; dmem_ack_i = e.dack;
      zero_i = e.zero; instr_i = e.instr;
      #1;
      check_eq("state", 32'(state_o), 32'(e.st));
      check_eq("strobes", 32'({imem_req_o, ir_load_o, dmem_req_o, dmem_we_o, reg_we_o,
                               pc_inc_o, pc_load_o}), 32'(e.strb));
      check_eq("halted", 32'(halted_o), 32'(e.st == 3'd6));
      check_eq("err", 32'(err_o), 32'(e.st == 3'd7));
      check_eq("retired", 32'(retired_o), 32'(m_ret));
      check_eq("fields", 32'({opcode_o, funct_o, imm_code_o}), 32'({m_op, m_funct, m_imm}));
      if (e.load) begin
        m_op = e.instr[11:9]; m_funct = e.instr[8]; m_imm = e.instr[1:0];
      end
      if (e.retire) m_ret = m_ret + 16'd1;
    end
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    start_i = 1'b0;
    @(posedge clk_i);
    #1;
    check_eq("rst_state", 32'(state_o), 32'd0);
    check_eq("rst_strobes", 32'({imem_req_o, ir_load_o, dmem_req_o, dmem_we_o, reg_we_o,
                                 pc_inc_o, pc_load_o}), 32'd0);
    check_eq("rst_fields", 32'({opcode_o, funct_o, imm_code_o}), 32'd0);
    check_eq("rst_retired", 32'(retired_o), 32'd0);
    check_eq("rst_err_halt", 32'({err_o, halted_o}), 32'd0);
    m_ret = 16'd0; m_op = 3'd0; m_funct = 1'b0; m_imm = 2'd0;
    rst_n_i = 1'b1;
  endtask

  initial begin
    int k;
    logic [2:0] op;
    rst_n_i = 1'b0; start_i = 1'b0; zero_i = 1'b0; imem_ack_i = 1'b0;
    dmem_ack_i = 1'b0; instr_i = 12'h000;
    do_reset();

    // Directed: addi, ld with 3-cycle ack delay, jdne both ways, str.
    start_seq(2);
    build_instr(12'h400, 0, 0, 1'b0);
    build_instr(12'h802, 1, 3, 1'b0);
    build_instr(12'hC00, 0, 0, 1'b0);
    build_instr(12'hC01, 2, 0, 1'b1);
    build_instr(12'h903, 0, 2, 1'b0);
    build_instr(12'hD00, 0, 0, 1'b1);
    run_trace();

    // Random instruction stream (no halts).
    for (int n = 0; n < 80; n++) begin
      op = 3'($urandom_range(0, 7));
      if (op == 3'd5) op = 3'd7;
      build_instr({op, rnd12() & 12'h1FF}, $urandom_range(0, 3), $urandom_range(0, 4), rnd1());
    end
    run_trace();

    // Halt is absorbing for 20 cycles despite start and acks.
    build_instr(12'hA03, 1, 0, 1'b0);
    repeat (19) push(3'd6, 7'b0, rnd1(), rnd1(), rnd1(), rnd1(), rnd12(), 1'b0, 1'b0);
    run_trace();
    do_reset();

    // Reset while a load waits for its data ack.
    start_seq(0);
    build_instr(12'h800, 0, 5, 1'b0);
    k = -1;
    foreach (trace[i]) if (k < 0 && trace[i].st == 3'd4) k = i;
    trace = trace[0:k];
    run_trace();
    do_reset();

    // Fetch with no instruction ack.
    start_seq(1);
`ifdef SEQ_MEM_TIMEOUT_EN
    repeat (16) push(3'd1, S_IREQ, rnd1(), 1'b0, rnd1(), rnd1(), rnd12(), 1'b0, 1'b0);
    repeat (6) push(3'd7, 7'b0, rnd1(), rnd1(), rnd1(), rnd1(), rnd12(), 1'b0, 1'b0);
`else
    repeat (100) push(3'd1, S_IREQ, rnd1(), 1'b0, rnd1(), rnd1(), rnd12(), 1'b0, 1'b0);
`endif
    run_trace();
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/proc_sequencer.md
PROC_SEQUENCER -- requirements
Module: proc_sequencer

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 16, memory-handshake watchdog limit in cycles (range 2..255; used only with SEQ_MEM_TIMEOUT_EN).
REQ-002 SHALL have ports:
- clk_i  in  1  single clock; all state changes on rising edge.
- rst_n_i  in  1  synchronous, active-low reset.
- start_i  in  1  leave IDLE and begin fetching.
- instr_i  in  12  instruction word: opcode [11:9], funct [8], imm_code [1:0].
- zero_i  in  1  ALU compare result, valid during EXEC.
- imem_ack_i  in  1  instruction memory done; instr_i valid this cycle.
- dmem_ack_i  in  1  data memory done.
- imem_req_o  out  1  instruction fetch request.
- ir_load_o  out  1  capture instr_i into the instruction register.
- opcode_o  out  3  latched opcode, to the immediate calculator.
- funct_o  out  1  latched funct.
- imm_code_o  out  2  latched imm_code.
- dmem_req_o  out  1  data memory request.
- dmem_we_o  out  1  data memory write; qualifies dmem_req_o.
- reg_we_o  out  1  register file write enable.
- pc_inc_o  out  1  PC += 1.
- pc_load_o  out  1  PC <= branch target.
- state_o  out  3  current state encoding.
- halted_o  out  1  high while in HALT.
- err_o  out  1  sticky memory-timeout error.
- retired_o  out  16  retired-instruction count.

Function
REQ-003 SHALL use states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERROR=7, with state_o equal to the current state.
REQ-004 IDLE SHALL go to FETCH on start_i=1; otherwise it SHALL stay in IDLE.
REQ-005 FETCH SHALL hold imem_req_o=1 until imem_ack_i=1; in the ack cycle it SHALL pulse ir_load_o, latch opcode/funct/imm_code, and go to DECODE next cycle.
REQ-006 DECODE SHALL last one cycle, then go to HALT if opcode=5, otherwise to EXEC.
REQ-007 EXEC SHALL last one cycle, with the following next state by opcode:
- 4 -> MEM.
- 6 -> FETCH; pc_load_o=1 if (funct=0 and zero_i=0) or (funct=1 and zero_i=1), else pc_inc_o=1.
- all others -> WB.
REQ-008 MEM SHALL hold dmem_req_o=1 until dmem_ack_i=1, with dmem_we_o=funct (1=str, 0=ld); on ack it SHALL go to WB if funct=0, else to FETCH with pc_inc_o=1.
REQ-009 WB SHALL last one cycle with reg_we_o=1 and pc_inc_o=1, then go to FETCH.
REQ-010 retired_o SHALL increment by 1 on every exit to FETCH from EXEC, MEM or WB, and SHALL wrap 0xFFFF->0x0000.
REQ-011 All strobe outputs (imem_req_o, ir_load_o, dmem_req_o, dmem_we_o, reg_we_o, pc_inc_o, pc_load_o) SHALL be Moore/state-qualified, high only in the states named above.
REQ-012 pc_inc_o and pc_load_o SHALL never be high in the same cycle.
REQ-013 An ack arriving in a state not expecting it SHALL be ignored.
REQ-014 HALT and ERROR SHALL be absorbing; only reset leaves them.
REQ-015 halted_o SHALL be 1 exactly when state=HALT.
REQ-016 Latched opcode/funct/imm_code SHALL change only on ir_load_o.

Reset
REQ-017 rst_n_i=0 sampled at a clock edge SHALL force, on that edge: state=IDLE, all strobes=0, opcode_o/funct_o/imm_code_o=0, retired_o=0, err_o=0, halted_o=0.
REQ-018 Reset asserted mid-handshake SHALL abandon the transaction immediately, with no further strobes after that edge.

Configuration
REQ-019 With SEQ_MEM_TIMEOUT_EN defined, an 8-bit wait counter SHALL:
- clear on entry to FETCH or MEM;
- increment each cycle the request is held without ack;
- on reaching TIMEOUT_CYCLES without ack, drop the request next cycle, set err_o=1, and go to ERROR.
REQ-020 Without SEQ_MEM_TIMEOUT_EN, the counter SHALL not exist, handshakes SHALL wait indefinitely, err_o SHALL be constant 0, and ERROR SHALL be unreachable.

Verification
REQ-021 Reset, then start_i=1, then instr 0x2_0 (addi) with ack in the first fetch cycle -> states 1,2,3,5,1; reg_we_o=1 for one cycle; retired_o=1.
REQ-022 ld (opcode 4, funct 0) with dmem_ack_i delayed 3 cycles -> dmem_req_o high for 4 cycles, dmem_we_o=0, then WB with reg_we_o=1.
REQ-023 jdne (opcode 6, funct 0) with zero_i=0 -> pc_load_o=1 and pc_inc_o=0; repeated with zero_i=1 -> pc_inc_o=1.
REQ-024 opcode 5 -> state 6; halted_o=1 and stays 1 for 20 cycles despite start_i and acks; reset -> state 0.
REQ-025 With SEQ_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=16, no imem_ack_i -> state 7 and err_o=1 after 16 request cycles; without the macro -> still in FETCH at cycle 100.
REQ-026 rst_n_i low in the MEM wait cycle -> next cycle: state 0, dmem_req_o=0, retired_o=0.
